// File: rtl/lemon_ifu_if.sv
// Instruction-memory bus between the LemonPC fetch unit (master) and memory (slave).
// Valid/ready request channel plus a valid-only response channel.
interface lemon_ifu_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err
  );
endinterface

// File: rtl/lemon_ifu.sv
// LemonPC instruction fetch unit: owns the PC, fetches one instruction at a time,
// holds it until execute commits, and stops on ebreak or a fetch fault.
module lemon_ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  lemon_ifu_if.master imem,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [63:0] pc,
  input  logic        inst_ready,
  input  logic [63:0] next_pc,
  input  logic        halt_req,
  output logic        halted,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [63:0] fault_pc,
  output logic [63:0] retire_cnt
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [1:0] CAUSE_BUS     = 2'b01;
  localparam logic [1:0] CAUSE_ALIGN   = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    REQ   = 3'd0,
    WAIT  = 3'd1,
    HOLD  = 3'd2,
    HALT  = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t            state_reg;
  logic [63:0]       pc_reg;
  logic [31:0]       inst_reg;
  logic [1:0]        fault_cause_reg;
  logic [63:0]       fault_pc_reg;
  logic [63:0]       retire_cnt_reg;
  logic [CNT_W-1:0]  wait_cnt_reg;
  logic              timeout_hit;

  // Fires on the edge where the count of elapsed WAIT cycles would reach TIMEOUT.
  assign timeout_hit = (TIMEOUT != 0) && ((32'(wait_cnt_reg) + 32'd1) == TIMEOUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= REQ;
      pc_reg          <= RESET_PC;
      inst_reg        <= '0;
      fault_cause_reg <= '0;
      fault_pc_reg    <= '0;
      retire_cnt_reg  <= '0;
      wait_cnt_reg    <= '0;
    end else begin
      case (state_reg)
        REQ: begin
          if (imem.imem_req_ready) begin
            state_reg <= WAIT;
          end
        end

        WAIT: begin
          // A response in the same cycle as the timeout still wins.
          if (imem.imem_resp_valid) begin
            wait_cnt_reg <= '0;
            if (imem.imem_resp_err) begin
              fault_cause_reg <= CAUSE_BUS;
              fault_pc_reg    <= pc_reg;
              state_reg       <= FAULT;
            end else begin
              inst_reg  <= imem.imem_resp_data;
              state_reg <= HOLD;
            end
          end else if (timeout_hit) begin
            wait_cnt_reg    <= '0;
            fault_cause_reg <= CAUSE_TIMEOUT;
            fault_pc_reg    <= pc_reg;
            state_reg       <= FAULT;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
          end
        end

        HOLD: begin
          if (inst_ready) begin
            // The committing instruction retires even when its jump target faults.
            retire_cnt_reg <= retire_cnt_reg + 64'd1;
            if (halt_req) begin
              state_reg <= HALT;
            end else if (next_pc[1:0] != 2'b00) begin
              fault_cause_reg <= CAUSE_ALIGN;
              fault_pc_reg    <= next_pc;
              state_reg       <= FAULT;
            end else begin
              pc_reg    <= next_pc;
              state_reg <= REQ;
            end
          end
        end

        default: begin
          state_reg <= state_reg;
        end
      endcase
    end
  end

  assign imem.imem_req_valid = (state_reg == REQ);
  assign imem.imem_req_addr  = pc_reg;

  assign inst_valid  = (state_reg == HOLD);
  assign inst        = inst_reg;
  assign pc          = pc_reg;
  assign halted      = (state_reg == HALT);
  assign fault       = (state_reg == FAULT);
  assign fault_cause = fault_cause_reg;
  assign fault_pc    = fault_pc_reg;
  assign retire_cnt  = retire_cnt_reg;

endmodule

// File: tb/tb_lemon_ifu.sv
// Directed plus randomized bench for lemon_ifu; memory and execute side are driven
// cycle by cycle while a simple PC/retire model tracks the expected architectural state.
module tb_lemon_ifu;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
  localparam int          TIMEOUT  = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] pc;
  logic        inst_ready;
  logic [63:0] next_pc;
  logic        halt_req;
  logic        halted;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [63:0] fault_pc;
  logic [63:0] retire_cnt;

  lemon_ifu_if bus ();

  lemon_ifu #(
    .RESET_PC (RESET_PC),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (bus),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .pc          (pc),
    .inst_ready  (inst_ready),
    .next_pc     (next_pc),
    .halt_req    (halt_req),
    .halted      (halted),
    .fault       (fault),
    .fault_cause (fault_cause),
    .fault_pc    (fault_pc),
    .retire_cnt  (retire_cnt)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_pc;
  logic [63:0] exp_retire;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Sample and drive 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.imem_resp_err   = 1'b0;
    inst_ready          = 1'b0;
    next_pc             = '0;
    halt_req            = 1'b0;
  endtask

  // Asynchronous reset: outputs are checked before any clock edge, while a stray
  // response is presented that must have no effect.
  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    #1;
    chk("rst_inst_valid", 64'(inst_valid), 64'd0);
    chk("rst_inst", 64'(inst), 64'd0);
    chk("rst_pc", pc, RESET_PC);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);
    chk("rst_fault_cause", 64'(fault_cause), 64'd0);
    chk("rst_fault_pc", fault_pc, 64'd0);
    chk("rst_retire_cnt", retire_cnt, 64'd0);
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 32'hdead_beef;
    tick();
    tick();
    idle_inputs();
    rst_n      = 1'b1;
    exp_pc     = RESET_PC;
    exp_retire = 64'd0;
  endtask

  // Issue a request at exp_pc and accept it after rdly cycles of ready low.
  task automatic request(input int rdly);
    chk("req_valid", 64'(bus.imem_req_valid), 64'd1);
    chk("req_addr", bus.imem_req_addr, exp_pc);
    for (int i = 0; i < rdly; i++) begin
      bus.imem_req_ready  = 1'b0;
      bus.imem_resp_valid = 1'($urandom_range(0, 1));
      bus.imem_resp_data  = $urandom;
      tick();
      chk("req_addr_held", bus.imem_req_addr, exp_pc);
      chk("req_valid_held", 64'(bus.imem_req_valid), 64'd1);
    end
    bus.imem_resp_valid = 1'b0;
    bus.imem_req_ready  = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    chk("wait_req_low", 64'(bus.imem_req_valid), 64'd0);
  endtask

  // One complete instruction: request, response, hold, commit.
  task automatic fetch(input int rdly, input int sdly, input bit err, input logic [31:0] data,
                       input int hold, input logic [63:0] nxt, input bit halt);
    logic [63:0] this_pc;
    this_pc = exp_pc;
    request(rdly);
    for (int i = 0; i < sdly; i++) begin
      inst_ready = 1'($urandom_range(0, 1));
      tick();
      chk("wait_inst_valid", 64'(inst_valid), 64'd0);
    end
    inst_ready          = 1'b0;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = data;
    bus.imem_resp_err   = err;
    tick();
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_err   = 1'b0;
    if (err) begin
      chk("buserr_fault", 64'(fault), 64'd1);
      chk("buserr_cause", 64'(fault_cause), 64'd1);
      chk("buserr_fault_pc", fault_pc, this_pc);
      chk("buserr_inst_valid", 64'(inst_valid), 64'd0);
      $display("fetch pc=%h bus error retire=%0d", this_pc, exp_retire);
      return;
    end
    chk("hold_inst_valid", 64'(inst_valid), 64'd1);
    chk("hold_inst", 64'(inst), 64'(data));
    chk("hold_pc", pc, this_pc);
    for (int i = 0; i < hold; i++) begin
      inst_ready = 1'b0;
      halt_req   = 1'($urandom_range(0, 1));
      next_pc    = {$urandom, $urandom};
      tick();
      chk("stall_inst", 64'(inst), 64'(data));
      chk("stall_pc", pc, this_pc);
      chk("stall_inst_valid", 64'(inst_valid), 64'd1);
    end
    inst_ready = 1'b1;
    next_pc    = nxt;
    halt_req   = halt;
    tick();
    inst_ready = 1'b0;
    halt_req   = 1'b0;
    exp_retire = exp_retire + 64'd1;
    chk("retire_cnt", retire_cnt, exp_retire);
    if (halt) begin
      chk("halt_halted", 64'(halted), 64'd1);
      chk("halt_req_valid", 64'(bus.imem_req_valid), 64'd0);
      chk("halt_pc", pc, this_pc);
    end else if (nxt[1:0] != 2'b00) begin
      chk("align_fault", 64'(fault), 64'd1);
      chk("align_cause", 64'(fault_cause), 64'd2);
      chk("align_fault_pc", fault_pc, nxt);
      chk("align_req_valid", 64'(bus.imem_req_valid), 64'd0);
    end else begin
      exp_pc = nxt;
      chk("next_req_valid", 64'(bus.imem_req_valid), 64'd1);
      chk("next_req_addr", bus.imem_req_addr, nxt);
      chk("next_inst_valid", 64'(inst_valid), 64'd0);
    end
    $display("fetch pc=%h inst=%h next=%h halt=%0d retire=%0d", this_pc, data, nxt, halt, exp_retire);
  endtask

  // Stopped states must stay stopped and silent on the bus.
  task automatic check_absorbed(input string tag, input bit exp_halt, input bit exp_fault);
    for (int i = 0; i < 4; i++) begin
      bus.imem_req_ready  = 1'b1;
      bus.imem_resp_valid = 1'($urandom_range(0, 1));
      inst_ready          = 1'b1;
      next_pc             = exp_pc + 64'd4;
      tick();
      chk({tag, "_req_valid"}, 64'(bus.imem_req_valid), 64'd0);
      chk({tag, "_halted"}, 64'(halted), 64'(exp_halt));
      chk({tag, "_fault"}, 64'(fault), 64'(exp_fault));
      chk({tag, "_retire"}, retire_cnt, exp_retire);
    end
    idle_inputs();
  endtask

  initial begin
    logic [63:0] nxt;
    rst_n = 1'b1;
    idle_inputs();
    #2;

    // Single ebreak with zero-wait memory.
    do_reset();
    fetch(0, 0, 1'b0, 32'h0010_0073, 0, RESET_PC + 64'd4, 1'b1);
    check_absorbed("ebreak", 1'b1, 1'b0);

    // Stalled sequential stream, then a misaligned jump.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      fetch(0, 0, 1'b0, 32'h0010_0093 + 32'(k), 5, exp_pc + 64'd4, 1'b0);
    end
    chk("seq_retire3", retire_cnt, 64'd3);
    chk("seq_pc", pc, RESET_PC + 64'd12);
    fetch(0, 1, 1'b0, 32'h0000_006f, 0, 64'h0000_0000_8000_0102, 1'b0);
    check_absorbed("misalign", 1'b0, 1'b1);

    // Bus error on the second fetch.
    do_reset();
    fetch(0, 0, 1'b0, 32'h0010_0093, 0, exp_pc + 64'd4, 1'b0);
    fetch(0, 2, 1'b1, 32'h0000_0013, 0, 64'd0, 1'b0);
    check_absorbed("buserr", 1'b0, 1'b1);

    // Delayed acceptance, then no response until the timeout fires.
    do_reset();
    request(7);
    for (int i = 1; i < TIMEOUT; i++) begin
      tick();
      chk("to_not_yet", 64'(fault), 64'd0);
    end
    tick();
    chk("to_fault", 64'(fault), 64'd1);
    chk("to_cause", 64'(fault_cause), 64'd3);
    chk("to_fault_pc", fault_pc, RESET_PC);
    check_absorbed("timeout", 1'b0, 1'b1);

    // Reset in the middle of WAIT with a late response during reset.
    do_reset();
    fetch(0, 0, 1'b0, 32'h0010_0093, 0, exp_pc + 64'd4, 1'b0);
    request(0);
    tick();
    tick();
    do_reset();
    chk("restart_req_valid", 64'(bus.imem_req_valid), 64'd1);
    chk("restart_addr", bus.imem_req_addr, RESET_PC);
    fetch(1, 0, 1'b0, 32'h0020_0113, 1, exp_pc + 64'd4, 1'b0);

    // Randomized stream with jumps and variable timing, ending on ebreak.
    do_reset();
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 3) == 0) nxt = {$urandom, $urandom} & ~64'h3;
      else                           nxt = exp_pc + 64'd4;
      fetch(int'($urandom_range(0, 3)), int'($urandom_range(0, 6)), 1'b0, $urandom,
            int'($urandom_range(0, 4)), nxt, (k == 29));
    end
    check_absorbed("rand_end", 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/lemon_ifu.md
Name: lemon_ifu

Overview:
- Instruction fetch unit for the LemonPC single-cycle core; sits directly upstream of the instruction decoder/control.
- Owns the architectural PC and fetches 32-bit instructions over a valid/ready request, valid response memory interface.
- Holds each instruction stable until the execute side accepts it, then steps to the next PC, which the downstream pc_sel mux supplies.
- Stops on ebreak and on fetch faults.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset.
- TIMEOUT, 16, maximum cycles spent in WAIT before a timeout fault; 0 disables the timeout.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  64  fetch address; equals pc.
- imem_resp_valid  in  1  response data valid.
- imem_resp_data  in  32  fetched instruction.
- imem_resp_err  in  1  bus error flag, qualified by imem_resp_valid.
- inst_valid  out  1  inst/pc are valid for decode.
- inst  out  32  instruction to control/decoder.
- pc  out  64  PC of the current instruction.
- inst_ready  in  1  execute commits the current instruction this cycle.
- next_pc  in  64  PC selected downstream (snpc or alu), sampled at commit.
- halt_req  in  1  ebreak_flag from control, sampled at commit.
- halted  out  1  core stopped by ebreak.
- fault  out  1  fetch fault latched.
- fault_cause  out  2  01 = bus error, 10 = misaligned next_pc, 11 = timeout, 00 = none.
- fault_pc  out  64  address that faulted.
- retire_cnt  out  64  count of committed instructions.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values:
  - state = REQ, pc = RESET_PC.
  - inst = 0, inst_valid = 0, halted = 0, fault = 0, fault_cause = 0, fault_pc = 0, retire_cnt = 0, wait counter = 0.
  - imem_req_valid = 1 from the first cycle after rst_n deasserts.
  - Reset asserted mid-operation aborts any outstanding fetch immediately. Outputs are state-decoded from registers, so they take reset values asynchronously.
- States: REQ, WAIT, HOLD, HALT, FAULT. No other state is reachable.
- REQ:
  - imem_req_valid = 1, imem_req_addr = pc.
  - Exits to WAIT on imem_req_valid && imem_req_ready. Otherwise stays.
  - The address is stable while the request is valid and not yet accepted.
- WAIT:
  - imem_req_valid = 0. The wait counter increments every cycle.
  - On imem_resp_valid && !imem_resp_err: inst <= imem_resp_data, go to HOLD.
  - On imem_resp_valid && imem_resp_err: fault_cause <= 01, fault_pc <= pc, go to FAULT.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT without a response: fault_cause <= 11, fault_pc <= pc, go to FAULT.
  - The counter clears on leaving WAIT.
  - The response is ignored in every state except WAIT. Memory responds at least 1 cycle after the request is accepted.
- HOLD:
  - inst_valid = 1. inst and pc are stable.
  - Response-to-inst_valid latency is 1 cycle, registered.
  - On inst_ready, in priority order:
    1. halt_req = 1: go to HALT, halted = 1, retire_cnt += 1, pc unchanged.
    2. next_pc[1:0] != 0: fault_cause <= 10, fault_pc <= next_pc, go to FAULT. retire_cnt += 1, since the faulting jump itself commits.
    3. Otherwise: pc <= next_pc, retire_cnt += 1, go to REQ. The next request is issued the following cycle.
  - inst_ready while inst_valid = 0 is ignored.
- HALT and FAULT:
  - Absorbing until reset. imem_req_valid = 0, inst_valid = 0.
  - fault = 1 only in FAULT. halted = 1 only in HALT.
- retire_cnt wraps modulo 2^64.
- Best-case throughput is 1 instruction per 3 cycles (REQ, WAIT, HOLD) with zero-wait memory and immediate inst_ready.

Test Plan:
- Reset then zero-wait memory returning 32'h00100073 (ebreak) with halt_req = 1 and immediate inst_ready -> first imem_req_addr = 8000_0000. inst_valid one cycle after the response. halted = 1 and retire_cnt = 1 afterward. No further requests.
- Sequential addi stream with next_pc = pc+4 and inst_ready held low 5 cycles per instruction -> inst and pc stable while held. Addresses 8000_0000, 8000_0004, 8000_0008. retire_cnt = 3.
- Jump with next_pc = 8000_0102 -> fault = 1, fault_cause = 10, fault_pc = 8000_0102, retire_cnt incremented, imem_req_valid stays 0.
- imem_resp_err = 1 on the second fetch -> fault_cause = 01, fault_pc = 8000_0004, inst_valid never asserted for it.
- imem_req_ready low 7 cycles, then no response for TIMEOUT = 16 cycles -> request address held for 7 cycles, then fault_cause = 11 exactly 16 cycles after acceptance.
- rst_n pulsed low while in WAIT, with a late response arriving during reset -> outputs at reset values immediately. The late response is ignored. Fetch restarts at RESET_PC.
